// File: rtl/coin_pkg.sv
// Shared definitions for the coin-counting datapath.
//  - Coin values in quarters (25 kr units).
//  - Transaction FSM state encoding.
//  - Seven-segment digit table used by the display blocks.
package coin_pkg;

  localparam logic [2:0] Q_BIR      = 3'd4;
  localparam logic [2:0] Q_ELLI     = 3'd2;
  localparam logic [2:0] Q_YIRMIBES = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2,
    GAPW   = 2'd3
  } coin_state_e;

  // Segment pattern {g,f,e,d,c,b,a}, active high; non-decimal codes blank.
  function automatic logic [6:0] seg7Digit(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'h00;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/coin_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one raw coin sensor.
//  clk_i    : system clock
//  reset_ni : synchronous active-low reset
//  sensor_i : asynchronous raw sensor level
//  edge_o   : one-cycle pulse on a synchronised rising edge
module coin_edge_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic sensor_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  // All three flops reset to 1 so a sensor that is already high when reset
  // is released looks like a steady level, not a fresh coin.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/coin_accept_ctrl.sv
// Coin acceptance and transaction controller.
// Credit is kept in quarters; coins are serialised bir > elli > yirmibes,
// vend and change-return are sequenced, change leaves as one-coin pulses.
//  clk_in, reset          : clock, synchronous active-low reset
//  bir, elli, yirmibes    : raw asynchronous coin sensors (4, 2, 1 quarters)
//  vend_req, cancel       : synchronous requests, honoured only in IDLE
//  credit_q, coin_cnt     : current credit (quarters), coins this transaction
//  busy                   : state is not IDLE
//  vend_pulse, ret_*      : registered one-cycle dispense / change strobes
//  reject                 : registered one-cycle overflow strobe
module coin_accept_ctrl
  import coin_pkg::*;
#(
  parameter int PRICE_Q      = 6,
  parameter int CREDIT_MAX_Q = 39,
  parameter int CW           = 6,
  parameter int GAP          = 2
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          bir,
  input  logic          elli,
  input  logic          yirmibes,
  input  logic          vend_req,
  input  logic          cancel,
  output logic [CW-1:0] credit_q,
  output logic [7:0]    coin_cnt,
  output logic          busy,
  output logic          vend_pulse,
  output logic          ret_bir,
  output logic          ret_elli,
  output logic          ret_yirmibes,
  output logic          reject
);

  localparam logic [CW-1:0] PRICE_C      = CW'(PRICE_Q);
  localparam logic [CW:0]   CREDIT_MAX_C = (CW+1)'(CREDIT_MAX_Q);
  localparam logic [7:0]    GAP_LAST     = 8'(GAP - 1);

  coin_state_e   state_q, state_d;
  logic [CW-1:0] creditAcc_q, creditAcc_d;
  logic [7:0]    coinCnt_q, coinCnt_d;
  logic [7:0]    gapCnt_q, gapCnt_d;
  logic [2:0]    pend_q;
  logic [2:0]    coinEdge;
  logic [2:0]    svcMask;
  logic [2:0]    coinVal;
  logic [CW:0]   creditSum;
  logic          vendPulse_q, vendPulse_d;
  logic          retBir_q, retBir_d;
  logic          retElli_q, retElli_d;
  logic          retYirmibes_q, retYirmibes_d;
  logic          reject_q, reject_d;

  // Bit order everywhere: [2] = bir, [1] = elli, [0] = yirmibes.
  coin_edge_sync uSyncBir (
    .clk_i(clk_in), .reset_ni(reset), .sensor_i(bir), .edge_o(coinEdge[2])
  );
  coin_edge_sync uSyncElli (
    .clk_i(clk_in), .reset_ni(reset), .sensor_i(elli), .edge_o(coinEdge[1])
  );
  coin_edge_sync uSyncYirmibes (
    .clk_i(clk_in), .reset_ni(reset), .sensor_i(yirmibes), .edge_o(coinEdge[0])
  );

  // Arbiter, accumulator and FSM next-state. A pending coin is serviced
  // before any request; the sum is one bit wider so overflow is visible.
  always_comb begin
    state_d       = state_q;
    creditAcc_d   = creditAcc_q;
    coinCnt_d     = coinCnt_q;
    gapCnt_d      = gapCnt_q;
    svcMask       = 3'b000;
    coinVal       = 3'd0;
    creditSum     = {1'b0, creditAcc_q};
    vendPulse_d   = 1'b0;
    retBir_d      = 1'b0;
    retElli_d     = 1'b0;
    retYirmibes_d = 1'b0;
    reject_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q != 3'b000) begin
          if (pend_q[2]) begin
            svcMask = 3'b100;
            coinVal = Q_BIR;
          end else if (pend_q[1]) begin
            svcMask = 3'b010;
            coinVal = Q_ELLI;
          end else begin
            svcMask = 3'b001;
            coinVal = Q_YIRMIBES;
          end
          creditSum = {1'b0, creditAcc_q} + (CW+1)'(coinVal);
          if (creditSum <= CREDIT_MAX_C) begin
            creditAcc_d = creditSum[CW-1:0];
            if (coinCnt_q != 8'hFF) begin
              coinCnt_d = coinCnt_q + 8'd1;
            end
          end else begin
            reject_d = 1'b1;
          end
        end else if (vend_req) begin
          if (creditAcc_q >= PRICE_C) begin
            state_d = VEND;
          end
        end else if (cancel && (creditAcc_q != '0)) begin
          state_d = CHANGE;
        end
      end

      VEND: begin
        vendPulse_d = 1'b1;
        creditAcc_d = creditAcc_q - PRICE_C;
        if (creditAcc_d != '0) begin
          state_d = CHANGE;
        end else begin
          state_d   = IDLE;
          coinCnt_d = 8'd0;
        end
      end

      CHANGE: begin
        if (creditAcc_q >= CW'(Q_BIR)) begin
          retBir_d    = 1'b1;
          creditAcc_d = creditAcc_q - CW'(Q_BIR);
        end else if (creditAcc_q >= CW'(Q_ELLI)) begin
          retElli_d   = 1'b1;
          creditAcc_d = creditAcc_q - CW'(Q_ELLI);
        end else begin
          retYirmibes_d = 1'b1;
          creditAcc_d   = creditAcc_q - CW'(Q_YIRMIBES);
        end
        if (creditAcc_d == '0) begin
          state_d   = IDLE;
          coinCnt_d = 8'd0;
        end else begin
          state_d  = GAPW;
          gapCnt_d = 8'd0;
        end
      end

      GAPW: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d  = CHANGE;
          gapCnt_d = 8'd0;
        end else begin
          gapCnt_d = gapCnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and strobe registers. A fresh edge on a coin whose
  // flag is still set simply keeps it set, so the two arrivals merge.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q       <= IDLE;
      creditAcc_q   <= '0;
      coinCnt_q     <= 8'd0;
      gapCnt_q      <= 8'd0;
      pend_q        <= 3'b000;
      vendPulse_q   <= 1'b0;
      retBir_q      <= 1'b0;
      retElli_q     <= 1'b0;
      retYirmibes_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      creditAcc_q   <= creditAcc_d;
      coinCnt_q     <= coinCnt_d;
      gapCnt_q      <= gapCnt_d;
      pend_q        <= (pend_q & ~svcMask) | coinEdge;
      vendPulse_q   <= vendPulse_d;
      retBir_q      <= retBir_d;
      retElli_q     <= retElli_d;
      retYirmibes_q <= retYirmibes_d;
      reject_q      <= reject_d;
    end
  end

  assign credit_q     = creditAcc_q;
  assign coin_cnt     = coinCnt_q;
  assign busy         = (state_q != IDLE);
  assign vend_pulse   = vendPulse_q;
  assign ret_bir      = retBir_q;
  assign ret_elli     = retElli_q;
  assign ret_yirmibes = retYirmibes_q;
  assign reject       = reject_q;

endmodule

// File: tb/tb_coin_accept_ctrl.sv
// Scoreboard bench for coin_accept_ctrl. Stimulus tasks compute the expected
// event stream from credit arithmetic and queue it; the monitor pops one
// entry per observed DUT event (strobe or credit change) and compares.
module tb_coin_accept_ctrl;

  localparam int PRICE_Q      = 6;
  localparam int CREDIT_MAX_Q = 39;
  localparam int CW           = 6;
  localparam int GAP          = 2;

  localparam int EV_CREDIT = 0;
  localparam int EV_REJECT = 1;
  localparam int EV_VEND   = 2;
  localparam int EV_RB     = 3;
  localparam int EV_RE     = 4;
  localparam int EV_RY     = 5;

  localparam int OP_COIN   = 0;
  localparam int OP_VEND   = 1;
  localparam int OP_CANCEL = 2;

  logic          clk_in = 1'b0;
  logic          reset = 1'b0;
  logic          bir = 1'b0, elli = 1'b0, yirmibes = 1'b0;
  logic          vend_req = 1'b0, cancel = 1'b0;
  logic [CW-1:0] credit_q;
  logic [7:0]    coin_cnt;
  logic          busy, vend_pulse, ret_bir, ret_elli, ret_yirmibes, reject;

  coin_accept_ctrl #(
    .PRICE_Q(PRICE_Q), .CREDIT_MAX_Q(CREDIT_MAX_Q), .CW(CW), .GAP(GAP)
  ) dut (
    .clk_in(clk_in), .reset(reset), .bir(bir), .elli(elli),
    .yirmibes(yirmibes), .vend_req(vend_req), .cancel(cancel),
    .credit_q(credit_q), .coin_cnt(coin_cnt), .busy(busy),
    .vend_pulse(vend_pulse), .ret_bir(ret_bir), .ret_elli(ret_elli),
    .ret_yirmibes(ret_yirmibes), .reject(reject)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int credit;
    int cnt;
    int cyc;
  } ev_t;

  ev_t expQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  mCredit = 0;
  int  mCnt = 0;
  bit  monEn = 1'b0;
  int  prevCredit = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushEv(input int k, input int c, input int n, input int t);
    ev_t e;
    e.kind = k; e.credit = c; e.cnt = n; e.cyc = t;
    expQ.push_back(e);
  endfunction

  // Greedy change-out of the whole model credit, first strobe at cycle t.
  function automatic void modelChange(input int t);
    int tt;
    int k;
    tt = t;
    while (mCredit > 0) begin
      if (mCredit >= 4) begin k = EV_RB; mCredit -= 4; end
      else if (mCredit >= 2) begin k = EV_RE; mCredit -= 2; end
      else begin k = EV_RY; mCredit -= 1; end
      if (mCredit == 0) mCnt = 0;
      pushEv(k, mCredit, mCnt, tt);
      tt += GAP + 1;
    end
  endfunction

  // Coins applied together are credited one per cycle, bir first.
  function automatic void modelCoins(input logic [2:0] mask, input int t);
    int idx;
    int val;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      val = (i == 0) ? 4 : ((i == 1) ? 2 : 1);
      if (mask[2-i]) begin
        if (mCredit + val <= CREDIT_MAX_Q) begin
          mCredit += val;
          if (mCnt < 255) mCnt++;
          pushEv(EV_CREDIT, mCredit, mCnt, t + idx);
        end else begin
          pushEv(EV_REJECT, mCredit, mCnt, t + idx);
        end
        idx++;
      end
    end
  endfunction

  // Monitor: any strobe or credit change is one DUT event.
  always @(negedge clk_in) begin
    int kind;
    int nStrobe;
    ev_t e;
    if (monEn) begin
      nStrobe = int'(vend_pulse) + int'(ret_bir) + int'(ret_elli) +
                int'(ret_yirmibes) + int'(reject);
      kind = -1;
      if (vend_pulse) kind = EV_VEND;
      else if (ret_bir) kind = EV_RB;
      else if (ret_elli) kind = EV_RE;
      else if (ret_yirmibes) kind = EV_RY;
      else if (reject) kind = EV_REJECT;
      else if (int'(credit_q) != prevCredit) kind = EV_CREDIT;
      if (kind >= 0) begin
        checkOutput("strobe_count", nStrobe, (kind == EV_CREDIT) ? 0 : 1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", kind, -1);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_kind", kind, e.kind);
          checkOutput("event_credit", int'(credit_q), e.credit);
          checkOutput("event_coin_cnt", int'(coin_cnt), e.cnt);
          if (e.cyc >= 0) checkOutput("event_cycle", cyc, e.cyc);
        end
      end
      prevCredit = int'(credit_q);
    end
  end

  task automatic waitQueue(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    checkOutput({name, "_pending_events"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitDrain(input string name);
    waitQueue(name);
    repeat (6) @(negedge clk_in);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_credit"}, int'(credit_q), mCredit);
    checkOutput({name, "_coin_cnt"}, int'(coin_cnt), mCnt);
  endtask

  task automatic applyStimulus(input int op, input logic [2:0] mask);
    int t;
    @(negedge clk_in);
    t = cyc;
    case (op)
      OP_COIN: begin
        modelCoins(mask, t + 4);
        {bir, elli, yirmibes} = mask;
        repeat (3) @(negedge clk_in);
        {bir, elli, yirmibes} = 3'b000;
      end
      OP_VEND: begin
        if (mCredit >= PRICE_Q) begin
          mCredit -= PRICE_Q;
          if (mCredit == 0) mCnt = 0;
          pushEv(EV_VEND, mCredit, mCnt, t + 2);
          modelChange(t + 3);
        end
        vend_req = 1'b1;
        @(negedge clk_in);
        vend_req = 1'b0;
      end
      default: begin
        modelChange(t + 2);
        cancel = 1'b1;
        @(negedge clk_in);
        cancel = 1'b0;
      end
    endcase
    waitDrain("op");
  endtask

  initial begin
    int t;
    int r;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_credit", int'(credit_q), 0);
    checkOutput("reset_coin_cnt", int'(coin_cnt), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_strobes", int'({vend_pulse, ret_bir, ret_elli, ret_yirmibes, reject}), 0);
    reset = 1'b1;
    prevCredit = 0;
    monEn = 1'b1;
    repeat (2) @(negedge clk_in);

    // Separate coins: elli, elli, yirmibes
    applyStimulus(OP_COIN, 3'b010);
    applyStimulus(OP_COIN, 3'b010);
    applyStimulus(OP_COIN, 3'b001);
    checkOutput("t1_credit", int'(credit_q), 5);
    checkOutput("t1_coin_cnt", int'(coin_cnt), 3);

    // Insufficient vend is ignored, cancel returns bir then yirmibes
    applyStimulus(OP_VEND, 3'b000);
    checkOutput("t4_credit_after_vend", int'(credit_q), 5);
    applyStimulus(OP_CANCEL, 3'b000);
    checkOutput("t4_credit_after_cancel", int'(credit_q), 0);

    // Three coins on the same cycle, then vend with one quarter change
    applyStimulus(OP_COIN, 3'b111);
    checkOutput("t2_credit", int'(credit_q), 7);
    applyStimulus(OP_VEND, 3'b000);
    checkOutput("t3_credit", int'(credit_q), 0);
    checkOutput("t3_coin_cnt", int'(coin_cnt), 0);

    // Overflow: 38 quarters, elli rejected, yirmibes reaches the maximum
    for (int i = 0; i < 9; i++) applyStimulus(OP_COIN, 3'b100);
    applyStimulus(OP_COIN, 3'b010);
    checkOutput("t5_credit_38", int'(credit_q), 38);
    applyStimulus(OP_COIN, 3'b010);
    checkOutput("t5_credit_after_reject", int'(credit_q), 38);
    checkOutput("t5_cnt_after_reject", int'(coin_cnt), 10);
    applyStimulus(OP_COIN, 3'b001);
    checkOutput("t5_credit_max", int'(credit_q), 39);
    applyStimulus(OP_CANCEL, 3'b000);

    // Coin arriving during change is credited after returning to IDLE
    applyStimulus(OP_COIN, 3'b100);
    applyStimulus(OP_COIN, 3'b001);
    @(negedge clk_in);
    t = cyc;
    modelChange(t + 2);
    mCredit = 2;
    mCnt = 1;
    pushEv(EV_CREDIT, 2, 1, t + 6);
    cancel = 1'b1;
    @(negedge clk_in);
    cancel = 1'b0;
    @(negedge clk_in);
    elli = 1'b1;
    repeat (3) @(negedge clk_in);
    elli = 1'b0;
    waitDrain("coin_in_change");

    // Reset in GAPW with credit 3; bir held high across release
    applyStimulus(OP_COIN, 3'b001);
    checkOutput("t6_credit_3", int'(credit_q), 3);
    @(negedge clk_in);
    t = cyc;
    pushEv(EV_RE, 1, 2, t + 2);
    cancel = 1'b1;
    @(negedge clk_in);
    cancel = 1'b0;
    waitQueue("t6_first_change");
    monEn = 1'b0;
    reset = 1'b0;
    bir = 1'b1;
    @(negedge clk_in);
    checkOutput("t6_reset_credit", int'(credit_q), 0);
    checkOutput("t6_reset_coin_cnt", int'(coin_cnt), 0);
    checkOutput("t6_reset_busy", int'(busy), 0);
    checkOutput("t6_reset_strobes", int'({vend_pulse, ret_bir, ret_elli, ret_yirmibes, reject}), 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    mCredit = 0;
    mCnt = 0;
    prevCredit = 0;
    monEn = 1'b1;
    repeat (10) @(negedge clk_in);
    checkOutput("t6_bir_held_credit", int'(credit_q), 0);
    bir = 1'b0;
    repeat (6) @(negedge clk_in);
    checkOutput("t6_bir_release_credit", int'(credit_q), 0);
    checkOutput("t6_busy", int'(busy), 0);

    // Randomised mix of coins, vends and cancels
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) applyStimulus(OP_COIN, 3'($urandom_range(1, 7)));
      else if (r < 85) applyStimulus(OP_VEND, 3'b000);
      else applyStimulus(OP_CANCEL, 3'b000);
    end
    applyStimulus(OP_CANCEL, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_accept_ctrl.md
Name: coin_accept_ctrl

Overview:
Transaction controller for the coin-counting datapath.
- Takes the three raw coin-sensor lines (bir = 1 TL, elli = 50 kr, yirmibes = 25 kr) and synchronises and edge-detects them.
- Serialises simultaneous arrivals into a credit accumulator kept in units of 25 kr (quarters).
- Sequences vend and change-return. Change is dispensed as timed one-coin pulses.
- Its credit and coin-count outputs feed the existing seven-segment display logic.

Parameters:
- PRICE_Q, 6, item price in quarters (6 = 1.50 TL).
- CREDIT_MAX_Q, 39, maximum credit in quarters; a coin that would exceed it is rejected.
- CW, 6, credit width. Must satisfy 2^CW > CREDIT_MAX_Q.
- GAP, 2, idle cycles between consecutive change pulses (GAP ≥ 1).

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- bir  in  1  raw 1 TL sensor, asynchronous level.
- elli  in  1  raw 50 kr sensor, asynchronous level.
- yirmibes  in  1  raw 25 kr sensor, asynchronous level.
- vend_req  in  1  synchronous level, vend request.
- cancel  in  1  synchronous level, return all credit.
- credit_q  out  CW  current credit in quarters.
- coin_cnt  out  8  coins accepted in the current transaction, saturates at 255.
- busy  out  1  high when the state is not IDLE.
- vend_pulse  out  1  one-cycle dispense strobe.
- ret_bir, ret_elli, ret_yirmibes  out  1 each  one-cycle change-coin strobes.
- reject  out  1  one-cycle strobe, coin refused for overflow.

Behaviour:

Reset (reset = 0 at a clk_in edge):
- All outputs become 0, state becomes IDLE, pending flags are cleared, gap counter is cleared.
- Synchroniser and edge flops load 1, so a sensor held high across reset release produces no credit.

Coin input path:
- Each sensor has 2 sync flops plus a prev flop; edge = sync2 & ~prev.
- If the input is first sampled high at edge k, its pending flag is set at edge k+2.
- A new edge on a coin whose flag is already set is merged into that flag (counted once).
- Edges are captured in every state, and during reset release as described above.

IDLE:
- Coins are serviced one per cycle, fixed priority bir > elli > yirmibes. Coin values are 4, 2 and 1 quarters.
- Servicing clears the flag.
- If credit_q + value ≤ CREDIT_MAX_Q: credit_q += value and coin_cnt++ (saturating), both on the same edge.
- Otherwise: reject = 1 for that cycle; credit_q and coin_cnt are unchanged.
- A pending coin has priority over vend_req and cancel in the same cycle.
- With no coin pending:
  - vend_req = 1 and credit_q ≥ PRICE_Q → VEND.
  - vend_req = 1 and credit_q < PRICE_Q → ignored.
  - Otherwise, cancel = 1 and credit_q > 0 → CHANGE.
  - vend_req takes priority over cancel.

VEND (1 cycle):
- vend_pulse = 1 and credit_q -= PRICE_Q.
- If the remainder is > 0 → CHANGE; otherwise → IDLE with coin_cnt cleared.

CHANGE:
- Greedy, one strobe per visit:
  - credit_q ≥ 4 → ret_bir, −4.
  - else credit_q ≥ 2 → ret_elli, −2.
  - else → ret_yirmibes, −1.
- If the new credit is 0 → IDLE with coin_cnt cleared; otherwise → GAPW.

GAPW:
- Holds for GAP cycles with all strobes 0, then → CHANGE.

General rules:
- Strobes are registered, never more than one strobe high per cycle, and each lasts exactly one cycle.
- cancel and vend_req are ignored outside IDLE.
- Coins arriving during VEND/CHANGE/GAPW stay pending and are credited after the return to IDLE, as a new transaction.
- Reset asserted in any state aborts the transaction with no further strobes; lost credit is by design.

Decomposition:
- Package coin_pkg holds:
  - coin value constants: Q_BIR = 4, Q_ELLI = 2, Q_YIRMIBES = 1;
  - state encoding: IDLE, VEND, CHANGE, GAPW;
  - the shared seven-segment digit table used by display blocks.
- Sub-module coin_edge_sync: 2-flop synchroniser, prev flop and rising-edge pulse, reset-to-1. Instantiated three times.
- FSM, arbiter and accumulator stay in coin_accept_ctrl.

Test Plan:
1. Reset; elli pulse, elli pulse, yirmibes pulse, each well separated → credit_q = 5, coin_cnt = 3, reject never high.
2. bir, elli and yirmibes rise on the same cycle → credit_q steps 0→4→6→7 on consecutive edges, starting at edge k+3.
3. Credit 7, PRICE_Q = 6, vend_req for 1 cycle → vend_pulse 1 cycle, then a single ret_yirmibes; credit_q = 0, coin_cnt = 0, busy low.
4. Credit 5:
   - vend_req → nothing happens, credit_q stays 5.
   - then cancel → ret_bir, 2 idle cycles, ret_yirmibes; credit_q = 0.
5. Credit 38, insert elli → reject for 1 cycle; credit_q = 38; coin_cnt unchanged. Then insert yirmibes → credit_q = 39.
6. Reset asserted mid-GAPW with credit 3 → all outputs 0 at the next edge. bir held high through reset release → credit_q stays 0.
